// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the streaming pooling engine.
//   pool_state_t : frame FSM states (LOAD, COMPUTE, OUTPUT)
//   pool_mode_t  : reduction kind (POOL_MAX, POOL_AVG)
//   pool_out_dim : pooled map side length for a given map/window/stride
//   cnt_width    : counter width able to hold 0..n-1 (at least 1 bit)
package pool_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } pool_state_t;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_t;

    function automatic int unsigned pool_out_dim(input int unsigned mat,
                                                 input int unsigned win,
                                                 input int unsigned stride);
        return (mat - win) / stride + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_stream_multi_if.sv
// Stream bundle for pool_stream_multi: input beat handshake, output result
// handshake, frame_done pulse and (with POOL_AVG_EN) the pool_mode select.
//   slave  : the pooling engine side
//   master : the producer/consumer (or testbench) side
// Optional signal: pool_mode exists only when POOL_AVG_EN is defined.
interface pool_stream_multi_if #(
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned CHANNEL_COUNT = 2
);
    localparam int unsigned BUS_W = CHANNEL_COUNT * DATAWIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] out_data;
    logic             out_last;
    logic             frame_done;
`ifdef POOL_AVG_EN
    logic             pool_mode;
`endif

    modport slave (
`ifdef POOL_AVG_EN
        input  pool_mode,
`endif
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_done
    );

    modport master (
`ifdef POOL_AVG_EN
        output pool_mode,
`endif
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_done
    );

endinterface

// File: rtl/pool_lane_reduce.sv
// One lane of the window reduction: folds one element per enabled cycle into
// an accumulator and registers the finished window value on 'last'.
//   clk, rst : clock, synchronous active-high reset
//   en       : an element is presented this cycle
//   first    : element seeds the accumulator
//   last     : element completes the window; result updates
//   element  : signed lane element
//   mode     : max/average (only with POOL_AVG_EN)
//   result   : registered window result, held until the next window completes
// Build option: POOL_AVG_EN adds the wide accumulator and constant divider.
module pool_lane_reduce
    import pool_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned WIN_ELEMS = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        first,
    input  logic                        last,
    input  logic signed [DATAWIDTH-1:0] element,
`ifdef POOL_AVG_EN
    input  pool_mode_t                  mode,
`endif
    output logic signed [DATAWIDTH-1:0] result
);

`ifdef POOL_AVG_EN
    // Sum of WIN_ELEMS signed values needs $clog2(WIN_ELEMS) guard bits.
    localparam int unsigned ACC_W = DATAWIDTH + $clog2(WIN_ELEMS);
    localparam logic signed [ACC_W-1:0] DIVISOR = ACC_W'(WIN_ELEMS);
`else
    localparam int unsigned ACC_W = DATAWIDTH;
`endif

    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     elem_ext_c;
    logic signed [ACC_W-1:0]     next_c;
    logic signed [DATAWIDTH-1:0] final_c;

    assign elem_ext_c = ACC_W'(element);

    // Next accumulator value and the window result it implies.
    always_comb begin
        next_c = elem_ext_c;
        if (!first) begin
            next_c = (elem_ext_c > acc) ? elem_ext_c : acc;
`ifdef POOL_AVG_EN
            if (mode == POOL_AVG) begin
                next_c = acc + elem_ext_c;
            end
`endif
        end
        final_c = DATAWIDTH'(next_c);
`ifdef POOL_AVG_EN
        // Signed division truncates toward zero; quotient fits DATAWIDTH.
        if (mode == POOL_AVG) begin
            final_c = DATAWIDTH'(next_c / DIVISOR);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
        end else if (en) begin
            acc <= next_c;
            if (last) begin
                result <= final_c;
            end
        end
    end

endmodule

// File: rtl/pool_stream_multi.sv
// Streaming multi-channel 2-D pooling engine. Buffers a row-major frame,
// reduces each WINDOW_DIMENSION^2 window one element per cycle on all lanes
// in parallel, and streams the pooled map out with out_last on the final one.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pool_stream_multi_if.slave (in_*, out_*, frame_done, pool_mode)
// Build option: POOL_AVG_EN enables pool_mode and average pooling.
module pool_stream_multi
    import pool_pkg::*;
#(
    parameter int unsigned DATAWIDTH        = 32,
    parameter int unsigned MAT_DIMENSION    = 27,
    parameter int unsigned WINDOW_DIMENSION = 3,
    parameter int unsigned STRIDE           = 2,
    parameter int unsigned CHANNEL_COUNT    = 2
) (
    input logic                clk,
    input logic                rst,
    pool_stream_multi_if.slave bus
);

    localparam int unsigned OUTPUT_DIMENSION = pool_out_dim(MAT_DIMENSION, WINDOW_DIMENSION, STRIDE);
    localparam int unsigned NPIX      = MAT_DIMENSION * MAT_DIMENSION;
    localparam int unsigned WIN_ELEMS = WINDOW_DIMENSION * WINDOW_DIMENSION;
    localparam int unsigned BUS_W     = CHANNEL_COUNT * DATAWIDTH;
    localparam int unsigned CW        = cnt_width(MAT_DIMENSION);
    localparam int unsigned OW        = cnt_width(OUTPUT_DIMENSION);
    localparam int unsigned KW        = cnt_width(WINDOW_DIMENSION);
    localparam int unsigned PW        = cnt_width(NPIX);

    pool_state_t      state;
    logic             accept_en;
    logic             result_valid;
    logic             result_last;
    logic             done_pulse;
    logic [CW-1:0]    row;
    logic [CW-1:0]    col;
    logic [OW-1:0]    orow;
    logic [OW-1:0]    ocol;
    logic [KW-1:0]    k_row;
    logic [KW-1:0]    k_col;
`ifdef POOL_AVG_EN
    pool_mode_t       mode_q;
`endif

    logic [BUS_W-1:0] frame_buf [NPIX];

    logic             load_fire_c;
    logic             k_first_c;
    logic             k_last_c;
    logic             compute_c;
    logic [PW-1:0]    wr_addr_c;
    logic [PW-1:0]    rd_addr_c;
    logic [BUS_W-1:0] rd_word_c;
    logic [DATAWIDTH-1:0] lane_result [CHANNEL_COUNT];
    logic [BUS_W-1:0] out_data_c;

    assign load_fire_c = (state == LOAD) && accept_en && bus.in_valid;
    assign compute_c   = (state == COMPUTE);
    assign k_first_c   = (k_row == '0) && (k_col == '0);
    assign k_last_c    = (k_row == KW'(WINDOW_DIMENSION - 1)) && (k_col == KW'(WINDOW_DIMENSION - 1));

    // k is kept as (k_row, k_col) = (k / W, k % W) so no divider is needed.
    assign wr_addr_c = PW'(32'(row) * MAT_DIMENSION + 32'(col));
    assign rd_addr_c = PW'((32'(orow) * STRIDE + 32'(k_row)) * MAT_DIMENSION
                           + 32'(ocol) * STRIDE + 32'(k_col));
    assign rd_word_c = frame_buf[rd_addr_c];

    // Frame storage; contents need no reset since LOAD overwrites every cell.
    always_ff @(posedge clk) begin
        if (load_fire_c && !rst) begin
            frame_buf[wr_addr_c] <= bus.in_data;
        end
    end

    // Frame FSM and position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            accept_en    <= 1'b0;
            result_valid <= 1'b0;
            result_last  <= 1'b0;
            done_pulse   <= 1'b0;
            row          <= '0;
            col          <= '0;
            orow         <= '0;
            ocol         <= '0;
            k_row        <= '0;
            k_col        <= '0;
`ifdef POOL_AVG_EN
            mode_q       <= POOL_MAX;
`endif
        end else begin
            done_pulse <= 1'b0;
            case (state)
                LOAD: begin
                    accept_en <= 1'b1;
                    if (load_fire_c) begin
`ifdef POOL_AVG_EN
                        if ((row == '0) && (col == '0)) begin
                            mode_q <= pool_mode_t'(bus.pool_mode);
                        end
`endif
                        if (col == CW'(MAT_DIMENSION - 1)) begin
                            col <= '0;
                            if (row == CW'(MAT_DIMENSION - 1)) begin
                                row       <= '0;
                                accept_en <= 1'b0;
                                orow      <= '0;
                                ocol      <= '0;
                                k_row     <= '0;
                                k_col     <= '0;
                                state     <= COMPUTE;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (k_col == KW'(WINDOW_DIMENSION - 1)) begin
                        k_col <= '0;
                        if (k_row == KW'(WINDOW_DIMENSION - 1)) begin
                            k_row        <= '0;
                            result_valid <= 1'b1;
                            result_last  <= (orow == OW'(OUTPUT_DIMENSION - 1)) &&
                                            (ocol == OW'(OUTPUT_DIMENSION - 1));
                            state        <= OUTPUT;
                        end else begin
                            k_row <= k_row + 1'b1;
                        end
                    end else begin
                        k_col <= k_col + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        result_valid <= 1'b0;
                        if (result_last) begin
                            result_last <= 1'b0;
                            done_pulse  <= 1'b1;
                            accept_en   <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            if (ocol == OW'(OUTPUT_DIMENSION - 1)) begin
                                ocol <= '0;
                                orow <= orow + 1'b1;
                            end else begin
                                ocol <= ocol + 1'b1;
                            end
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // One reducer per lane, all fed from the same buffer word.
    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_lane
        pool_lane_reduce #(
            .DATAWIDTH (DATAWIDTH),
            .WIN_ELEMS (WIN_ELEMS)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (compute_c),
            .first   (k_first_c),
            .last    (k_last_c),
            .element (rd_word_c[c*DATAWIDTH +: DATAWIDTH]),
`ifdef POOL_AVG_EN
            .mode    (mode_q),
`endif
            .result  (lane_result[c])
        );
    end

    always_comb begin
        out_data_c = '0;
        for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
            out_data_c[c*DATAWIDTH +: DATAWIDTH] = lane_result[c];
        end
    end

    assign bus.in_ready   = accept_en;
    assign bus.out_valid  = result_valid;
    assign bus.out_last   = result_last;
    assign bus.frame_done = done_pulse;
    assign bus.out_data   = out_data_c;

endmodule

// File: tb/tb_pool_stream_multi.sv
// Self-checking bench for pool_stream_multi (5x5 map, 3x3 window, stride 2,
// two lanes). Expected outputs come from a window-by-window reference model
// or from hand-derived constants. Average-mode tests need POOL_AVG_EN.
module tb_pool_stream_multi;
    import pool_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned MAT  = 5;
    localparam int unsigned WIN  = 3;
    localparam int unsigned STR  = 2;
    localparam int unsigned CH   = 2;
    localparam int unsigned OD   = (MAT - WIN) / STR + 1;
    localparam int unsigned NPIX = MAT * MAT;
    localparam int unsigned NOUT = OD * OD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    int px    [NPIX][CH];
    int exp_o [NOUT][CH];

    pool_stream_multi_if #(.DATAWIDTH(DW), .CHANNEL_COUNT(CH)) bus ();

    pool_stream_multi #(
        .DATAWIDTH        (DW),
        .MAT_DIMENSION    (MAT),
        .WINDOW_DIMENSION (WIN),
        .STRIDE           (STR),
        .CHANNEL_COUNT    (CH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void fill_ramp();
        for (int i = 0; i < int'(NPIX); i++) begin
            px[i][0] = i;
            px[i][1] = -i;
        end
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < int'(NPIX); i++)
            for (int c = 0; c < int'(CH); c++)
                px[i][c] = int'($urandom);
    endfunction

    // Reference: directly evaluate every window of the stored frame.
    function automatic void build_model(input bit avg);
        for (int orow = 0; orow < int'(OD); orow++)
            for (int ocol = 0; ocol < int'(OD); ocol++)
                for (int c = 0; c < int'(CH); c++) begin
                    longint s = 0;
                    int     m = px[(orow * STR) * MAT + ocol * STR][c];
                    for (int i = 0; i < int'(WIN); i++)
                        for (int j = 0; j < int'(WIN); j++) begin
                            int v = px[(orow * STR + i) * MAT + (ocol * STR + j)][c];
                            s += longint'(v);
                            if (v > m) m = v;
                        end
                    exp_o[orow * OD + ocol][c] = avg ? int'(s / longint'(WIN * WIN)) : m;
                end
    endfunction

    function automatic logic [CH*DW-1:0] pack_px(input int idx);
        logic [CH*DW-1:0] v;
        for (int c = 0; c < int'(CH); c++) v[c*DW +: DW] = px[idx][c];
        return v;
    endfunction

    function automatic int lane_of(input logic [CH*DW-1:0] v, input int c);
        return int'(v[c*DW +: DW]);
    endfunction

    // Streams px[] in; optional random gaps; pool_mode wanders after beat 0.
    task automatic send_frame(input bit gaps, input bit mode, output int last_cyc, output bit ok);
        int idx = 0;
        int guard = 0;
        int c0;
        bit v;
        bit acc;
        ok = 1'b1;
        last_cyc = 0;
        while (idx < int'(NPIX)) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = pack_px(idx);
`ifdef POOL_AVG_EN
            bus.pool_mode = (idx == 0) ? mode : 1'($urandom_range(0, 1));
`else
            if (mode) guard = guard + 0;
`endif
            acc = v && bus.in_ready;
            c0  = cyc;
            @(posedge clk); #1;
            if (acc) begin
                last_cyc = c0;
                idx++;
            end
            guard++;
            if (guard > 1000) begin
                ok = 1'b0;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Takes the next result with out_ready high; returns after its handshake.
    task automatic get_output(output logic [CH*DW-1:0] d, output logic last, output int vcyc,
                              output bit ok, output int rdy_hits);
        bus.out_ready = 1'b1;
        ok = 1'b0;
        rdy_hits = 0;
        d = '0;
        last = 1'b0;
        vcyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                d = bus.out_data;
                last = bus.out_last;
                vcyc = cyc;
                ok = 1'b1;
            end
            if (bus.in_ready) rdy_hits++;
            @(posedge clk); #1;
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_last=%b frame_done=%b, want all 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.frame_done);
        end
        n_tests++;
        if (bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%h want 0", bus.out_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", bus.in_ready);
        end
    endtask

    task automatic test_max_ramp();
        int e0[4] = '{12, 14, 22, 24};
        int e1[4] = '{0, -2, -10, -12};
        logic [CH*DW-1:0] d;
        logic l;
        int lc, vc, rh;
        bit ok, sok;
        fill_ramp();
        send_frame(1'b0, 1'b0, lc, sok);
        n_tests++;
        if (!sok) begin n_fail++; $display("FAIL max_ramp_send: in_ready timeout"); end
        for (int i = 0; i < 4; i++) begin
            get_output(d, l, vc, ok, rh);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL max_ramp_valid%0d: no out_valid", i); end
            n_tests++;
            if (lane_of(d, 0) !== e0[i] || lane_of(d, 1) !== e1[i]) begin
                n_fail++;
                $display("FAIL max_ramp_data%0d: got %0d/%0d want %0d/%0d",
                         i, lane_of(d, 0), lane_of(d, 1), e0[i], e1[i]);
            end
            n_tests++;
            if (l !== (i == 3)) begin
                n_fail++;
                $display("FAIL max_ramp_last%0d: out_last=%b want %b", i, l, (i == 3));
            end
        end
        n_tests++;
        if (bus.frame_done !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL max_ramp_done: frame_done=%b in_ready=%b want 1/1", bus.frame_done, bus.in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL max_ramp_done_pulse: frame_done=%b want 0", bus.frame_done);
        end
    endtask

    task automatic test_latency();
        logic [CH*DW-1:0] d;
        logic l;
        int lc, vc, prev, rh;
        bit ok, sok;
        fill_random();
        build_model(1'b0);
        send_frame(1'b1, 1'b0, lc, sok);
        prev = lc;
        for (int i = 0; i < int'(NOUT); i++) begin
            get_output(d, l, vc, ok, rh);
            n_tests++;
            if (!ok || (vc - prev) != 10) begin
                n_fail++;
                $display("FAIL latency%0d: spacing %0d cycles want 10 (ok=%b)", i, vc - prev, ok);
            end
            n_tests++;
            if (lane_of(d, 0) !== exp_o[i][0] || lane_of(d, 1) !== exp_o[i][1]) begin
                n_fail++;
                $display("FAIL latency_data%0d: got %0d/%0d want %0d/%0d",
                         i, lane_of(d, 0), lane_of(d, 1), exp_o[i][0], exp_o[i][1]);
            end
            prev = vc;
        end
    endtask

    task automatic test_random_max();
        logic [CH*DW-1:0] d;
        logic l;
        int lc, vc, rh;
        bit ok, sok;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            build_model(1'b0);
            send_frame(1'b1, 1'b0, lc, sok);
            for (int i = 0; i < int'(NOUT); i++) begin
                get_output(d, l, vc, ok, rh);
                n_tests++;
                if (!ok || lane_of(d, 0) !== exp_o[i][0] || lane_of(d, 1) !== exp_o[i][1] ||
                    l !== (i == int'(NOUT) - 1)) begin
                    n_fail++;
                    $display("FAIL rand_max f%0d o%0d: got %0d/%0d last=%b want %0d/%0d last=%b",
                             f, i, lane_of(d, 0), lane_of(d, 1), l,
                             exp_o[i][0], exp_o[i][1], (i == int'(NOUT) - 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [CH*DW-1:0] d;
        logic l;
        int lc, vc, rh;
        bit ok, sok, seen;
        fill_ramp();
        build_model(1'b0);
        bus.out_ready = 1'b0;
        send_frame(1'b0, 1'b0, lc, sok);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL bp_first_valid: no out_valid"); end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || lane_of(bus.out_data, 0) !== 12 ||
                lane_of(bus.out_data, 1) !== 0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d/%0d want 1 12/0",
                         i, bus.out_valid, lane_of(bus.out_data, 0), lane_of(bus.out_data, 1));
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < int'(NOUT); i++) begin
            get_output(d, l, vc, ok, rh);
            n_tests++;
            if (!ok || lane_of(d, 0) !== exp_o[i][0] || lane_of(d, 1) !== exp_o[i][1]) begin
                n_fail++;
                $display("FAIL bp_data%0d: got %0d/%0d want %0d/%0d",
                         i, lane_of(d, 0), lane_of(d, 1), exp_o[i][0], exp_o[i][1]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int e0[4] = '{12, 14, 22, 24};
        int e1[4] = '{0, -2, -10, -12};
        logic [CH*DW-1:0] d;
        logic l;
        int lc, vc, rh, extra;
        bit ok, sok;
        fill_random();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pack_px(i);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: in_ready=%b out_valid=%b want 0/0", bus.in_ready, bus.out_valid);
        end
        rst = 1'b0;
        fill_ramp();
        send_frame(1'b0, 1'b0, lc, sok);
        for (int i = 0; i < 4; i++) begin
            get_output(d, l, vc, ok, rh);
            n_tests++;
            if (!ok || lane_of(d, 0) !== e0[i] || lane_of(d, 1) !== e1[i]) begin
                n_fail++;
                $display("FAIL midrst_data%0d: got %0d/%0d want %0d/%0d",
                         i, lane_of(d, 0), lane_of(d, 1), e0[i], e1[i]);
            end
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) extra++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL midrst_extra: %0d cycles of out_valid after frame, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [CH*DW-1:0] d;
        logic l;
        int lc, vc, rh, hits;
        bit ok, sok;
        fill_random();
        build_model(1'b0);
        send_frame(1'b0, 1'b0, lc, sok);
        for (int i = 0; i < int'(NOUT); i++) begin
            get_output(d, l, vc, ok, rh);
            n_tests++;
            if (!ok || lane_of(d, 0) !== exp_o[i][0] || lane_of(d, 1) !== exp_o[i][1]) begin
                n_fail++;
                $display("FAIL b2b_a%0d: got %0d/%0d want %0d/%0d",
                         i, lane_of(d, 0), lane_of(d, 1), exp_o[i][0], exp_o[i][1]);
            end
        end
        n_tests++;
        if (bus.frame_done !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: frame_done=%b in_ready=%b want 1/1", bus.frame_done, bus.in_ready);
        end
        fill_random();
        build_model(1'b0);
        send_frame(1'b0, 1'b0, lc, sok);
        bus.in_valid = 1'b1;
        bus.in_data  = {CH{32'hDEAD_BEEF}};
        hits = 0;
        for (int i = 0; i < int'(NOUT); i++) begin
            get_output(d, l, vc, ok, rh);
            hits += rh;
            n_tests++;
            if (!ok || lane_of(d, 0) !== exp_o[i][0] || lane_of(d, 1) !== exp_o[i][1]) begin
                n_fail++;
                $display("FAIL b2b_b%0d: got %0d/%0d want %0d/%0d",
                         i, lane_of(d, 0), lane_of(d, 1), exp_o[i][0], exp_o[i][1]);
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL b2b_no_accept: in_ready high %0d cycles during compute/output, want 0", hits);
        end
    endtask

`ifdef POOL_AVG_EN
    task automatic test_avg();
        int e0[4] = '{6, 8, 16, 18};
        logic [CH*DW-1:0] d;
        logic l;
        int lc, vc, rh;
        bit ok, sok;
        fill_ramp();
        send_frame(1'b1, 1'b1, lc, sok);
        for (int i = 0; i < 4; i++) begin
            get_output(d, l, vc, ok, rh);
            n_tests++;
            if (!ok || lane_of(d, 0) !== e0[i] || lane_of(d, 1) !== -e0[i]) begin
                n_fail++;
                $display("FAIL avg_ramp%0d: got %0d/%0d want %0d/%0d",
                         i, lane_of(d, 0), lane_of(d, 1), e0[i], -e0[i]);
            end
        end
        for (int f = 0; f < 2; f++) begin
            fill_random();
            build_model(1'b1);
            send_frame(1'b1, 1'b1, lc, sok);
            for (int i = 0; i < int'(NOUT); i++) begin
                get_output(d, l, vc, ok, rh);
                n_tests++;
                if (!ok || lane_of(d, 0) !== exp_o[i][0] || lane_of(d, 1) !== exp_o[i][1]) begin
                    n_fail++;
                    $display("FAIL avg_rand f%0d o%0d: got %0d/%0d want %0d/%0d",
                             f, i, lane_of(d, 0), lane_of(d, 1), exp_o[i][0], exp_o[i][1]);
                end
            end
        end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef POOL_AVG_EN
        bus.pool_mode = 1'b0;
`endif
        test_reset();
        test_max_ramp();
        test_latency();
        test_random_max();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
`ifdef POOL_AVG_EN
        test_avg();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
